// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU logic-op codes, FSM states and default width
package alu_pkg;

   localparam int ALU_DATA_W = 32;

   typedef enum logic [1:0] {
      LOGIC_AND = 2'b00,
      LOGIC_OR  = 2'b01,
      LOGIC_XOR = 2'b10,
      LOGIC_NOR = 2'b11
   } logic_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } fsm_state_e;

endpackage

// File: rtl/bit8_logic.sv
// rtl/bit8_logic.sv - combinational one-slice AND/OR/XOR/NOR unit
module bit8_logic
   import alu_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic [1:0]   i_op,
   output logic [W-1:0] o_z
);

   always_comb begin
      o_z = '0;
      case (i_op)
         LOGIC_AND: o_z = i_a & i_b;
         LOGIC_OR:  o_z = i_a | i_b;
         LOGIC_XOR: o_z = i_a ^ i_b;
         LOGIC_NOR: o_z = ~(i_a | i_b);
         default:   o_z = '0;
      endcase
   end

endmodule

// File: rtl/slice_logic_seq.sv
// rtl/slice_logic_seq.sv - multi-cycle 32-bit logic unit, one slice per cycle
module slice_logic_seq
   import alu_pkg::*;
#(
   parameter int DATA_W  = ALU_DATA_W,
   parameter int SLICE_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [1:0]        in_op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_z,
   output logic              out_zero,
   output logic              busy
);

   localparam int NSLICE = DATA_W / SLICE_W;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

   fsm_state_e                       r_state;
   logic [CNT_W-1:0]                 r_cnt;
   logic [NSLICE-1:0][SLICE_W-1:0]   r_a;
   logic [NSLICE-1:0][SLICE_W-1:0]   r_b;
   logic [NSLICE-1:0][SLICE_W-1:0]   r_z;
   logic [1:0]                       r_op;
   logic                             r_in_ready;
   logic                             r_out_valid;
   logic                             r_busy;
   logic [SLICE_W-1:0]               w_z_slice;

   // Single shared slice; the counter steers which operand byte it sees.
   bit8_logic #(.W(SLICE_W)) u_slice (
      .i_a  (r_a[r_cnt]),
      .i_b  (r_b[r_cnt]),
      .i_op (r_op),
      .o_z  (w_z_slice)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= '0;
         r_z         <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a        <= in_a;
                  r_b        <= in_b;
                  r_op       <= in_op;
                  r_z        <= '0;
                  r_cnt      <= '0;
                  r_state    <= S_RUN;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            S_RUN: begin
               r_z[r_cnt] <= w_z_slice;
               if (r_cnt == LAST_CNT) begin
                  r_cnt       <= '0;
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_cnt       <= '0;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign out_z     = r_z;
   assign out_zero  = ~|r_z;

endmodule
